// File: rtl/scpu_control_fsm.sv
// Multicycle control sequencer for the sCPU accumulator datapath.
// Optional memory wait states are enabled by defining SCPU_CTRL_WAIT_EN.
module scpu_control_fsm #(
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          instr,
    input  logic                zero_flag,
    input  logic                mem_ready,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                addr_sel,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                acc_load,
    output logic                acc_src_sel,
    output logic                opnd_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LD  = 4'h4;
    localparam logic [3:0] OP_ST  = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_opc;
    logic       w_ready;
    logic       w_unused;

    assign w_opc = instr[7:4];

`ifdef SCPU_CTRL_WAIT_EN
    assign w_ready  = mem_ready;
    assign w_unused = ^instr[3:0];
`else
    // Zero-wait memory: the ready port is kept but never consulted.
    assign w_ready  = 1'b1;
    assign w_unused = ^{instr[3:0], mem_ready};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        addr_sel    = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        acc_load    = 1'b0;
        acc_src_sel = 1'b0;
        opnd_sel    = 1'b0;
        alu_op      = ALU_ADD;
        halted      = 1'b0;
        illegal     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd  = 1'b1;
                ir_load = w_ready;
                pc_inc  = w_ready;
                if (w_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_opc == OP_LD || w_opc == OP_ST) begin
                    w_next = S_MEM;
                end else if (w_opc == OP_HLT) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_FETCH;
                unique case (w_opc)
                    OP_NOP: ;
                    OP_LDI: begin
                        acc_load    = 1'b1;
                        acc_src_sel = 1'b1;
                        opnd_sel    = 1'b1;
                    end
                    OP_ADD: begin
                        acc_load = 1'b1;
                        opnd_sel = 1'b1;
                        alu_op   = ALU_ADD;
                    end
                    OP_SUB: begin
                        acc_load = 1'b1;
                        opnd_sel = 1'b1;
                        alu_op   = ALU_SUB;
                    end
                    OP_AND: begin
                        acc_load = 1'b1;
                        opnd_sel = 1'b1;
                        alu_op   = ALU_AND;
                    end
                    OP_JMP: pc_load = 1'b1;
                    OP_JZ:  pc_load = zero_flag;
                    // LD/ST/HLT never reach EXEC.
                    OP_LD, OP_ST, OP_HLT: ;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEM: begin
                addr_sel = 1'b1;
                if (w_opc == OP_ST) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd      = 1'b1;
                    acc_load    = w_ready;
                    acc_src_sel = 1'b1;
                end
                if (w_ready) w_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_scpu_control_fsm.sv
// Table-driven, scoreboard-checked bench for scpu_control_fsm.
// Covers both builds; wait-state checks follow SCPU_CTRL_WAIT_EN.
module tb_scpu_control_fsm;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] instr;
    logic       zero_flag;
    logic       mem_ready;
    logic       ir_load, pc_inc, pc_load, addr_sel;
    logic       mem_rd, mem_wr, acc_load, acc_src_sel;
    logic       opnd_sel, halted, illegal;
    logic [1:0] alu_op;

    scpu_control_fsm #(.ALU_OP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .zero_flag(zero_flag), .mem_ready(mem_ready),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .acc_load(acc_load), .acc_src_sel(acc_src_sel),
        .opnd_sel(opnd_sel), .alu_op(alu_op),
        .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector bit masks.
    localparam logic [12:0] IR  = 13'h1000;
    localparam logic [12:0] PCI = 13'h0800;
    localparam logic [12:0] PCL = 13'h0400;
    localparam logic [12:0] AS  = 13'h0200;
    localparam logic [12:0] RD  = 13'h0100;
    localparam logic [12:0] WR  = 13'h0080;
    localparam logic [12:0] AL  = 13'h0040;
    localparam logic [12:0] SRC = 13'h0020;
    localparam logic [12:0] OPS = 13'h0010;
    localparam logic [12:0] ASB = 13'h0004;
    localparam logic [12:0] AND = 13'h0008;
    localparam logic [12:0] HLT = 13'h0002;
    localparam logic [12:0] ILL = 13'h0001;
    localparam logic [12:0] NONE = 13'h0000;
    localparam logic [12:0] FET = RD | IR | PCI;

    logic [12:0] w_act;
    assign w_act = {ir_load, pc_inc, pc_load, addr_sel, mem_rd,
                    mem_wr, acc_load, acc_src_sel, opnd_sel,
                    alu_op, halted, illegal};

    typedef struct {
        string       name;
        logic        st;
        logic [7:0]  ins;
        logic        zf;
        logic        rdy;
        logic [12:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [12:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic vec_t mk(string n, logic s, logic [7:0] i,
                                logic z, logic r, logic [12:0] e);
        vec_t v;
        v.name = n; v.st = s; v.ins = i;
        v.zf = z; v.rdy = r; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name);
        logic [12:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", name, w_act);
        end else begin
            e = exp_q.pop_front();
            if (w_act !== e) begin
                n_err++;
                $display("FAIL %s: got %h want %h", name, w_act, e);
            end
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        start = v.st; instr = v.ins;
        zero_flag = v.zf; mem_ready = v.rdy;
        exp_q.push_back(v.exp);
        #1;
        check(v.name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        exp_q.push_back(NONE);
        #1;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; instr = 8'h00;
        zero_flag = 1'b0; mem_ready = 1'b1;
        #2;
        exp_q.push_back(NONE);
        check("por_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("idle_hold", 0, 8'h15, 0, 1, NONE));
        tbl.push_back(mk("idle_start", 1, 8'h15, 0, 1, NONE));
        tbl.push_back(mk("ldi_fetch", 0, 8'h15, 0, 1, FET));
        tbl.push_back(mk("ldi_dec",   0, 8'h15, 0, 1, NONE));
        tbl.push_back(mk("ldi_exec",  0, 8'h15, 0, 1, AL|SRC|OPS));
        tbl.push_back(mk("add_fetch", 0, 8'h23, 0, 1, FET));
        tbl.push_back(mk("add_dec",   0, 8'h23, 0, 1, NONE));
        tbl.push_back(mk("add_exec",  0, 8'h23, 0, 1, AL|OPS));
        tbl.push_back(mk("sub_fetch", 0, 8'h31, 0, 1, FET));
        tbl.push_back(mk("sub_dec",   0, 8'h31, 0, 1, NONE));
        tbl.push_back(mk("sub_exec",  0, 8'h31, 0, 1, AL|OPS|ASB));
        tbl.push_back(mk("and_fetch", 0, 8'h62, 0, 1, FET));
        tbl.push_back(mk("and_dec",   0, 8'h62, 0, 1, NONE));
        tbl.push_back(mk("and_exec",  0, 8'h62, 0, 1, AL|OPS|AND));
        tbl.push_back(mk("jmp_fetch", 1, 8'h7E, 0, 1, FET));
        tbl.push_back(mk("jmp_dec",   1, 8'h7E, 0, 1, NONE));
        tbl.push_back(mk("jmp_exec",  1, 8'h7E, 0, 1, PCL));
        tbl.push_back(mk("jz1_fetch", 0, 8'h8A, 1, 1, FET));
        tbl.push_back(mk("jz1_dec",   0, 8'h8A, 1, 1, NONE));
        tbl.push_back(mk("jz1_exec",  0, 8'h8A, 1, 1, PCL));
        tbl.push_back(mk("jz0_fetch", 0, 8'h8A, 0, 1, FET));
        tbl.push_back(mk("jz0_dec",   0, 8'h8A, 0, 1, NONE));
        tbl.push_back(mk("jz0_exec",  0, 8'h8A, 0, 1, NONE));
        tbl.push_back(mk("nop_fetch", 0, 8'h00, 1, 1, FET));
        tbl.push_back(mk("nop_dec",   0, 8'h00, 1, 1, NONE));
        tbl.push_back(mk("nop_exec",  0, 8'h00, 1, 1, NONE));
        tbl.push_back(mk("ill_fetch", 0, 8'h95, 0, 1, FET));
        tbl.push_back(mk("ill_dec",   0, 8'h95, 0, 1, NONE));
        tbl.push_back(mk("ill_exec",  0, 8'h95, 0, 1, ILL));
        tbl.push_back(mk("illE_fetch", 0, 8'hE3, 0, 1, FET));
        tbl.push_back(mk("illE_dec",  0, 8'hE3, 0, 1, NONE));
        tbl.push_back(mk("illE_exec", 0, 8'hE3, 0, 1, ILL));
        tbl.push_back(mk("ld_fetch",  0, 8'h4C, 0, 1, FET));
        tbl.push_back(mk("ld_dec",    0, 8'h4C, 0, 1, NONE));
        tbl.push_back(mk("ld_mem",    0, 8'h4C, 0, 1, AS|RD|AL|SRC));
        tbl.push_back(mk("st_fetch",  0, 8'h53, 0, 1, FET));
        tbl.push_back(mk("st_dec",    0, 8'h53, 0, 1, NONE));
        tbl.push_back(mk("st_mem",    0, 8'h53, 0, 1, AS|WR));
        tbl.push_back(mk("hlt_fetch", 0, 8'hF0, 0, 1, FET));
        tbl.push_back(mk("hlt_dec",   0, 8'hF0, 0, 1, NONE));
        tbl.push_back(mk("halt_0",    1, 8'hF0, 0, 1, HLT));
        tbl.push_back(mk("halt_1",    0, 8'h15, 0, 1, HLT));
        tbl.push_back(mk("halt_2",    1, 8'h23, 1, 1, HLT));
        tbl.push_back(mk("halt_3",    0, 8'h00, 0, 1, HLT));

        foreach (tbl[i]) step(tbl[i]);

        // Reset clears HALT.
        do_reset();
        step(mk("post_halt_idle", 0, 8'h00, 0, 1, NONE));

        // Async reset while a store is in MEM.
        step(mk("ar_start", 1, 8'h53, 0, 1, NONE));
        step(mk("ar_fetch", 0, 8'h53, 0, 1, FET));
        step(mk("ar_dec",   0, 8'h53, 0, 1, NONE));
        step(mk("ar_mem",   0, 8'h53, 0, 1, AS|WR));
        rst_n = 1'b0;
        exp_q.push_back(NONE);
        #1;
        check("ar_async_drop");
        @(negedge clk);
        rst_n = 1'b1;
        step(mk("ar_idle0", 0, 8'h53, 0, 1, NONE));
        step(mk("ar_idle1", 0, 8'h53, 0, 1, NONE));

`ifdef SCPU_CTRL_WAIT_EN
        step(mk("w_start",   1, 8'h4C, 0, 1, NONE));
        step(mk("w_fetch_w", 0, 8'h4C, 0, 0, RD));
        step(mk("w_fetch",   0, 8'h4C, 0, 1, FET));
        step(mk("w_dec",     0, 8'h4C, 0, 0, NONE));
        for (int i = 0; i < 3; i++)
            step(mk("w_ld_wait", 0, 8'h4C, 0, 0, AS|RD|SRC));
        step(mk("w_ld_ready", 0, 8'h4C, 0, 1, AS|RD|AL|SRC));
        step(mk("w_st_fetch", 0, 8'h53, 0, 1, FET));
        step(mk("w_st_dec",   0, 8'h53, 0, 1, NONE));
        step(mk("w_st_wait",  0, 8'h53, 0, 0, AS|WR));
        step(mk("w_st_ready", 0, 8'h53, 0, 1, AS|WR));
        step(mk("w_next_fetch", 0, 8'h00, 0, 1, FET));
`else
        step(mk("nw_start", 1, 8'h4C, 0, 0, NONE));
        step(mk("nw_fetch", 0, 8'h4C, 0, 0, FET));
        step(mk("nw_dec",   0, 8'h4C, 0, 0, NONE));
        step(mk("nw_ld",    0, 8'h4C, 0, 0, AS|RD|AL|SRC));
        step(mk("nw_fetch2", 0, 8'h00, 0, 0, FET));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
